// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-side memory responder.
//   - MMIO word offsets inside the 32-byte register window
//   - STATUS register bit positions
//   - address region type and the region decode helper
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [4:0] OFF_LED    = 5'h00;
    localparam logic [4:0] OFF_CYCLE  = 5'h04;
    localparam logic [4:0] OFF_TX     = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_CLR    = 5'h10;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;
    localparam int ST_MISALIGN  = 16;
    localparam int ST_OVERFLOW  = 17;
    localparam int ST_UNMAPPED  = 18;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_MMIO     = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    // RAM takes priority so a (mis)configured MMIO page can never shadow RAM.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [19:0] mmio_page);
        region_e r;
        if (addr < ram_bytes) begin
            r = REG_RAM;
        end else if (addr[31:12] == mmio_page) begin
            r = REG_MMIO;
        end else begin
            r = REG_UNMAPPED;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Circular byte buffer feeding the TX ready/valid drain port.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (empties the buffer)
//   push     in   write din this cycle (dropped when full without a pop)
//   din      in   data to write
//   pop      in   consume the head entry (ignored while empty)
//   dout     out  head entry, 0 while empty
//   empty    out  no entries
//   full     out  DEPTH entries
//   count    out  number of entries, 0..DEPTH
//   overflow out  one-cycle pulse: push rejected because full
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push onto a full buffer
    // is still accepted then.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Data-side responder for the single-cycle CPU: word RAM plus a small MMIO
// block (LED, cycle counter, TX byte FIFO, status/sticky errors).
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   MemWrite   in   store strobe
//   ALUResult  in   byte address
//   WriteData  in   store data
//   ReadData   out  load data, combinational from ALUResult
//   led        out  LED register
//   tx_data    out  TX FIFO head byte
//   tx_valid   out  TX FIFO non-empty
//   tx_ready   in   downstream takes head byte on tx_valid && tx_ready
//   err        out  registered OR of the sticky error flags
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_e            region;
    logic               aligned;
    logic [4:0]         word_off;
    logic [RAM_AW-1:0]  ram_idx;
    logic [31:0]        ram [RAM_WORDS];

    logic [7:0]         led_q;
    logic [31:0]        cycle_q;
    logic               misalign_q;
    logic               overflow_q;
    logic               unmapped_q;
    logic               err_q;

    logic               st_ram;
    logic               st_mmio;
    logic               st_led;
    logic               st_tx;
    logic               st_clr;
    logic               set_misalign;
    logic               set_unmapped;

    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_overflow;
    logic [CNT_W-1:0]   fifo_count;
    logic [7:0]         fifo_dout;
    logic [31:0]        status_word;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign region   = decode_region(ALUResult, RAM_BYTES, MMIO_BASE[31:12]);
    assign aligned  = (ALUResult[1:0] == 2'b00);
    // Loads ignore the byte lane; stores only get this far when aligned.
    assign word_off = {ALUResult[4:2], 2'b00};
    assign ram_idx  = ALUResult[RAM_AW+1:2];

    assign st_ram       = MemWrite && aligned && (region == REG_RAM);
    assign st_mmio      = MemWrite && aligned && (region == REG_MMIO);
    assign st_led       = st_mmio && (word_off == OFF_LED);
    assign st_tx        = st_mmio && (word_off == OFF_TX);
    assign st_clr       = st_mmio && (word_off == OFF_CLR) && WriteData[0];
    assign set_misalign = MemWrite && !aligned;
    assign set_unmapped = MemWrite && (region == REG_UNMAPPED);

    // ------------------------------------------------------------------
    // RAM: asynchronous read, synchronous write, no reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (st_ram) ram[ram_idx] <= WriteData;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (st_tx),
        .din      (WriteData[7:0]),
        .pop      (tx_ready),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    assign tx_data  = fifo_dout;
    assign tx_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // MMIO registers, cycle counter, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            cycle_q    <= '0;
            misalign_q <= 1'b0;
            overflow_q <= 1'b0;
            unmapped_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (st_led) led_q <= WriteData[7:0];
            // A new error in the same cycle as a clear leaves the flag set.
            misalign_q <= set_misalign  | (misalign_q & ~st_clr);
            overflow_q <= fifo_overflow | (overflow_q & ~st_clr);
            unmapped_q <= set_unmapped  | (unmapped_q & ~st_clr);
            err_q      <= misalign_q | overflow_q | unmapped_q;
        end
    end

    assign led = led_q;
    assign err = err_q;

    always_comb begin
        status_word                                = '0;
        status_word[ST_EMPTY]                      = fifo_empty;
        status_word[ST_FULL]                       = fifo_full;
        status_word[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
        status_word[ST_MISALIGN]                   = misalign_q;
        status_word[ST_OVERFLOW]                   = overflow_q;
        status_word[ST_UNMAPPED]                   = unmapped_q;
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    always_comb begin
        ReadData = '0;
        case (region)
            REG_RAM: ReadData = ram[ram_idx];
            REG_MMIO: begin
                case (word_off)
                    OFF_LED:    ReadData = {24'h0, led_q};
                    OFF_CYCLE:  ReadData = cycle_q;
                    OFF_STATUS: ReadData = status_word;
                    default:    ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed scenarios followed by a random mix, all checked against a
// queue/array reference model of the memory map.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int          RAM_WORDS = 1024;
    localparam int          DEPTH     = 8;
    localparam int          WIN       = 16;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_ram [WIN];
    logic [7:0]  m_fifo [$];
    logic [7:0]  m_led;
    logic [31:0] m_cycle;
    bit          m_mis;
    bit          m_ovf;
    bit          m_unm;
    bit          m_err;
    logic [31:0] rd_obs;

    always #5 clk = ~clk;

    data_mem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (32'h0000_1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .led       (led),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_led   = 8'h00;
        m_cycle = 32'h0;
        m_mis   = 1'b0;
        m_ovf   = 1'b0;
        m_unm   = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int          n;
        n = m_fifo.size();
        s = 32'(n) << 4;
        if (n == 0)     s = s | 32'h0000_0001;
        if (n == DEPTH) s = s | 32'h0000_0002;
        if (m_mis)      s = s | 32'h0001_0000;
        if (m_ovf)      s = s | 32'h0002_0000;
        if (m_unm)      s = s | 32'h0004_0000;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a < RAM_BYTES) begin
            v = m_ram[a[5:2]];
        end else if (a[31:12] == 20'h00001) begin
            case (a[4:2])
                3'd0:    v = {24'h0, m_led};
                3'd1:    v = m_cycle;
                3'd3:    v = m_status();
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    // One CPU cycle: drive, check outputs against the model, clock, update model.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        bit in_ram;
        bit in_mmio;
        bit pop;
        bit push;
        bit clr;
        bit n_mis;
        bit n_ovf;
        bit n_unm;
        MemWrite  = we;
        ALUResult = a;
        WriteData = wd;
        tx_ready  = rdy;
        #1;
        rd_obs = ReadData;
        check("read_data", ReadData, m_read(a));
        check("tx_valid", {31'h0, tx_valid}, {31'h0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, m_fifo[0]});
        check("led", {24'h0, led}, {24'h0, m_led});
        check("err", {31'h0, err}, {31'h0, m_err});
        @(posedge clk);
        in_ram  = (a < RAM_BYTES);
        in_mmio = !in_ram && (a[31:12] == 20'h00001);
        pop     = rdy && (m_fifo.size() != 0);
        push    = 1'b0;
        clr     = 1'b0;
        n_mis   = 1'b0;
        n_ovf   = 1'b0;
        n_unm   = 1'b0;
        m_err   = m_mis | m_ovf | m_unm;
        m_cycle = m_cycle + 32'd1;
        if (we) begin
            if (!in_ram && !in_mmio) n_unm = 1'b1;
            if (a[1:0] != 2'b00) begin
                n_mis = 1'b1;
            end else if (in_ram) begin
                m_ram[a[5:2]] = wd;
            end else if (in_mmio) begin
                case (a[4:0])
                    5'h00:   m_led = wd[7:0];
                    5'h08:   push = 1'b1;
                    5'h10:   clr = wd[0];
                    default: ;
                endcase
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(wd[7:0]);
            else n_ovf = 1'b1;
        end
        m_mis = n_mis || (m_mis && !clr);
        m_ovf = n_ovf || (m_ovf && !clr);
        m_unm = n_unm || (m_unm && !clr);
        @(negedge clk);
    endtask

    int unsigned op;
    bit          rdy_r;
    logic [31:0] a_r;
    logic [31:0] d_r;

    initial begin
        rst       = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        tx_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Reset state
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("reset_status", rd_obs, 32'h0000_0001);
        check("reset_led", {24'h0, led}, 32'h0);
        check("reset_txvalid", {31'h0, tx_valid}, 32'h0);

        // Initialise the RAM window used by the rest of the bench
        for (int i = 0; i < WIN; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0);

        // RAM round trip and misaligned store
        step(1'b1, 32'h0000_000C, 32'h0000_0010, 1'b0);
        step(1'b0, 32'h0000_000C, 32'h0, 1'b0);
        check("ram_rt", rd_obs, 32'h0000_0010);
        step(1'b1, 32'h0000_000E, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h0000_000E, 32'h0, 1'b0);
        check("ram_misaligned_load", rd_obs, 32'h0000_0010);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("misalign_flag", rd_obs & 32'h0007_0000, 32'h0001_0000);
        check("misalign_err", {31'h0, err}, 32'h1);

        // FIFO fill with overflow, then drain
        step(1'b1, 32'h0000_1010, 32'h1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 32'h0000_1008, 32'(8'h41 + i), 1'b0);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("fill_status", rd_obs, 32'h0002_0082);
        check("fill_head", {24'h0, tx_data}, 32'h0000_0041);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", {24'h0, tx_data}, 32'(8'h41 + i));
            step(1'b0, 32'h0000_100C, 32'h0, 1'b1);
        end
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("drained_status", rd_obs, 32'h0002_0001);

        // Push and pop together while full
        step(1'b1, 32'h0000_1010, 32'h1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0000_1008, 32'(8'h60 + i), 1'b0);
        step(1'b1, 32'h0000_1008, 32'h0000_0055, 1'b1);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("fullpp_status", rd_obs, 32'h0000_0082);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("fullpp_last", {24'h0, tx_data}, 32'h0000_0055);
            step(1'b0, 32'h0000_100C, 32'h0, 1'b1);
        end

        // Push and pop together while empty
        step(1'b1, 32'h0000_1008, 32'h0000_0077, 1'b1);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("emptypp_status", rd_obs & 32'h0000_01F3, 32'h0000_0010);
        check("emptypp_valid", {31'h0, tx_valid}, 32'h1);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b1);

        // Sticky unmapped and clear
        step(1'b1, 32'h8000_0000, 32'h1234, 1'b0);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("unmapped_flag", rd_obs & 32'h0004_0000, 32'h0004_0000);
        step(1'b1, 32'h0000_1010, 32'h1, 1'b0);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("clr_flags", rd_obs & 32'h0007_0000, 32'h0);
        step(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        check("clr_err", {31'h0, err}, 32'h0);
        step(1'b1, 32'h0000_1010, 32'h1, 1'b0);
        step(1'b1, 32'h8000_0000, 32'h0, 1'b0);
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("clr_then_err", rd_obs & 32'h0004_0000, 32'h0004_0000);

        // Cycle counter wrap
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFE;
        step(1'b0, 32'h0000_1004, 32'h0, 1'b0);
        check("cycle_pre", rd_obs, 32'hFFFF_FFFE);
        step(1'b0, 32'h0000_1004, 32'h0, 1'b0);
        step(1'b0, 32'h0000_1004, 32'h0, 1'b0);
        check("cycle_wrap", rd_obs, 32'h0000_0000);

        // LED
        step(1'b1, 32'h0000_1000, 32'h0000_01A5, 1'b0);
        step(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        check("led_read", rd_obs, 32'h0000_00A5);
        check("led_port", {24'h0, led}, 32'h0000_00A5);

        // Random mix
        for (int n = 0; n < 600; n++) begin
            op    = $urandom_range(0, 9);
            rdy_r = ($urandom_range(0, 9) < 4);
            d_r   = $urandom;
            case (op)
                0, 1, 2: begin
                    a_r = ($urandom_range(0, WIN - 1) << 2) | $urandom_range(0, 3);
                    step(1'b0, a_r, 32'h0, rdy_r);
                end
                3, 4: begin
                    a_r = $urandom_range(0, WIN - 1) << 2;
                    if ($urandom_range(0, 7) == 0) a_r = a_r | $urandom_range(1, 3);
                    step(1'b1, a_r, d_r, rdy_r);
                end
                5:       step(1'b1, 32'h0000_1008, d_r, rdy_r);
                6:       step(1'($urandom_range(0, 1)), 32'h0000_1000, d_r, rdy_r);
                7: begin
                    a_r = 32'h0000_1000 | ($urandom_range(0, 7) << 2);
                    step(1'b0, a_r, 32'h0, rdy_r);
                end
                8: begin
                    a_r = 32'h0000_2000 + ($urandom_range(0, 255) << 2);
                    step(1'($urandom_range(0, 1)), a_r, d_r, rdy_r);
                end
                default: step(1'b1, 32'h0000_1010, {31'h0, 1'($urandom_range(0, 1))}, rdy_r);
            endcase
        end

        // Reset mid-transfer
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0000_100C, 32'h0, 1'b1);
        step(1'b1, 32'h0000_1000, 32'h0000_005A, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_1008, 32'(8'h30 + i), 1'b0);
        check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        MemWrite  = 1'b0;
        ALUResult = 32'h0000_1004;
        tx_ready  = 1'b1;
        rst       = 1'b0;
        #1;
        check("rst_txvalid", {31'h0, tx_valid}, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_cycle", ReadData, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b0, 32'h0000_100C, 32'h0, 1'b0);
        check("post_rst_status", rd_obs, 32'h0000_0001);
        step(1'b0, 32'h0000_1004, 32'h0, 1'b0);
        check("post_rst_cycle", rd_obs, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
